// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the memory copy engine.
package mem_copy_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  // Cycles from a read strobe until memoryOutData holds the word.
  localparam int READ_LATENCY   = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-by-word ascending block copy over a single-port memory.
// Each word takes three cycles: READ, CAPTURE, WRITE. The engine sums
// every word it moves into a wrapping checksum. All outputs are decoded
// from registered state, so inputs have no combinational path to outputs.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] srcAddress,
  input  logic [ADDR_WIDTH-1:0] dstAddress,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  memoryWrite,
  output logic                  memoryRead,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  input  logic [DATA_WIDTH-1:0] memoryOutData
);

  // The capture stage assumes the word is valid exactly one cycle after READ.
  localparam int CAPTURE_LAT = READ_LATENCY;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE = (ADDR_WIDTH + 1)'(CAPTURE_LAT);
  localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;

  copy_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // State register; reset abandons any in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a zero-length request goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (length != REM_ZERO) ? READ : DONE;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = (remaining_q != REM_ONE) ? READ : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from state and datapath registers.
  always_comb begin
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    memoryRead      = (state_q == READ);
    memoryWrite     = (state_q == WRITE);
    memoryAddress   = '0;
    memoryWriteData = '0;
    if (state_q == READ) memoryAddress = src_ptr_q;
    if (state_q == WRITE) begin
      memoryAddress   = dst_ptr_q;
      memoryWriteData = data_q;
    end
  end

  // Datapath next values: load on accepted start, capture word, advance pointers.
  always_comb begin
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    checksum_d  = checksum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d   = srcAddress;
          dst_ptr_d   = dstAddress;
          remaining_d = length;
          checksum_d  = '0;
        end
      end
      CAPTURE: begin
        data_d     = memoryOutData;
        checksum_d = checksum_q + memoryOutData;
      end
      WRITE: begin
        // Pointers wrap naturally at the address width.
        src_ptr_d   = src_ptr_q + PTR_ONE;
        dst_ptr_d   = dst_ptr_q + PTR_ONE;
        remaining_d = remaining_q - REM_ONE;
      end
      default: ;
    endcase
  end

  // Datapath registers; checksum holds after DONE until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      checksum_q  <= '0;
    end else begin
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
    end
  end

  assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a memory responder, a transaction-level
// model producing the expected per-cycle bus trace, and directed tests.
module tb_mem_copy_engine;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] srcAddress = '0;
  logic [AW-1:0] dstAddress = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, memoryWrite, memoryRead;
  logic [DW-1:0] checksum, memoryWriteData, memoryOutData;
  logic [AW-1:0] memoryAddress;

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .srcAddress(srcAddress), .dstAddress(dstAddress), .length(length),
    .busy(busy), .done(done), .checksum(checksum),
    .memoryWrite(memoryWrite), .memoryRead(memoryRead),
    .memoryWriteData(memoryWriteData), .memoryAddress(memoryAddress),
    .memoryOutData(memoryOutData)
  );

  always #5 clk = ~clk;

  // Memory responder: synchronous write, one-cycle read latency.
  logic [DW-1:0] ram [256];
  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [DW-1:0] pk_data = '0;
  always @(posedge clk) begin
    if (pk_en)            ram[pk_addr] <= pk_data;
    else if (memoryWrite) ram[memoryAddress] <= memoryWriteData;
    if (memoryRead) memoryOutData <= ram[memoryAddress];
  end

  typedef struct packed {
    logic          busy, done, rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, cks;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] model_cks = '0;
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, done_at = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare of every output against the model trace.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else begin
      e = '0;
      e.cks = model_cks;
    end
    check("busy",  32'(busy),            32'(e.busy));
    check("done",  32'(done),            32'(e.done));
    check("rd",    32'(memoryRead),      32'(e.rd));
    check("wr",    32'(memoryWrite),     32'(e.wr));
    check("addr",  32'(memoryAddress),   32'(e.addr));
    check("wdata", 32'(memoryWriteData), 32'(e.wdata));
    check("cks",   32'(checksum),        32'(e.cks));
    check("rd_wr_excl", 32'(memoryRead & memoryWrite), 32'(0));
    if (done) begin
      done_cnt++;
      done_at = cyc - start_cyc + 1;
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pk_addr = a; pk_data = d; pk_en = 1'b1;
    model_mem[a] = d;
    @(posedge clk); #1 pk_en = 1'b0;
  endtask

  // Expected trace of a copy: three bus cycles per word then DONE.
  // Only the first 'commit' words update the model memory.
  task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int len, input int commit);
    logic [DW-1:0] sum, w;
    logic [AW-1:0] as, ad;
    exp_t e;
    sum = '0;
    for (int i = 0; i < len; i++) begin
      as = s + 8'(i);
      ad = d + 8'(i);
      w  = model_mem[as];
      e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = as; e.cks = sum; q.push_back(e);
      e = '0; e.busy = 1'b1; e.cks = sum; q.push_back(e);
      sum = sum + w;
      e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = ad; e.wdata = w; e.cks = sum; q.push_back(e);
      if (i < commit) model_mem[ad] = w;
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; e.cks = sum; q.push_back(e);
    model_cks = sum;
  endtask

  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input int len, input int commit, input bit hold);
    @(posedge clk); #2;
    srcAddress = s; dstAddress = d; length = 9'(len); start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    if (!hold) start = 1'b0;
    model_copy(s, d, len, commit);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 32'(q.size() == 0), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'(0));
    check({tag, "_done"},  32'(done), 32'(0));
    check({tag, "_rd"},    32'(memoryRead), 32'(0));
    check({tag, "_wr"},    32'(memoryWrite), 32'(0));
    check({tag, "_addr"},  32'(memoryAddress), 32'(0));
    check({tag, "_wdata"}, 32'(memoryWriteData), 32'(0));
    check({tag, "_cks"},   32'(checksum), 32'(0));
  endtask

  initial begin
    int d0, bad;
    logic [DW-1:0] pre;

    // Reset held from time zero.
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_idle");
    @(posedge clk); #2 rst = 1'b1;

    // Known background pattern in every word.
    for (int i = 0; i < 256; i++) poke(8'(i), 16'(i * 16'h0101) ^ 16'h5A00);

    // Basic copy.
    poke(8'h10, 16'h0001); poke(8'h11, 16'h0002);
    poke(8'h12, 16'h0003); poke(8'h13, 16'hABCD);
    d0 = done_cnt;
    launch(8'h10, 8'h40, 4, 4, 1'b0);
    drain();
    check("basic_done_cycle", 32'(done_at), 32'(13));
    check("basic_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("basic_cks", 32'(checksum), 32'h0000_ABD3);
    check("basic_m40", 32'(ram[8'h40]), 32'h0001);
    check("basic_m41", 32'(ram[8'h41]), 32'h0002);
    check("basic_m42", 32'(ram[8'h42]), 32'h0003);
    check("basic_m43", 32'(ram[8'h43]), 32'hABCD);

    // Reset while idle clears the held checksum.
    @(posedge clk); #2 rst = 1'b0; model_cks = '0;
    #1 check_all_zero("reset_idle2");
    @(posedge clk); #2 rst = 1'b1;

    // Zero length.
    launch(8'h05, 8'h06, 0, 0, 1'b0);
    drain();
    check("zero_done_cycle", 32'(done_at), 32'(1));
    check("zero_cks", 32'(checksum), 32'(0));

    // Pointer wrap; third read sees the word just written at 0x00.
    poke(8'hFE, 16'h1111); poke(8'hFF, 16'h2222); poke(8'h00, 16'h3333);
    launch(8'hFE, 8'h00, 3, 3, 1'b0);
    drain();
    check("wrap_m00", 32'(ram[8'h00]), 32'h1111);
    check("wrap_m01", 32'(ram[8'h01]), 32'h2222);
    check("wrap_m02", 32'(ram[8'h02]), 32'h1111);
    check("wrap_cks", 32'(checksum), 32'h4444);

    // Forward overlap smears the first word.
    poke(8'h20, 16'h5A5A);
    launch(8'h20, 8'h21, 4, 4, 1'b0);
    drain();
    for (int i = 1; i <= 4; i++) check("overlap_word", 32'(ram[8'h20 + 8'(i)]), 32'h5A5A);
    check("overlap_cks", 32'(checksum), 32'h6968);

    // Start while busy ignored; checksum overflow.
    poke(8'h30, 16'hFFFF); poke(8'h31, 16'h0002);
    d0 = done_cnt;
    launch(8'h30, 8'h50, 2, 2, 1'b0);
    repeat (3) @(posedge clk);
    #2 srcAddress = 8'h99; dstAddress = 8'hC0; length = 9'd7; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    drain();
    check("busy_start_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("ovf_cks", 32'(checksum), 32'h0001);
    check("ovf_m50", 32'(ram[8'h50]), 32'hFFFF);
    check("ovf_m51", 32'(ram[8'h51]), 32'h0002);

    // Start held through DONE retriggers after one IDLE cycle.
    poke(8'h60, 16'h1234);
    d0 = done_cnt;
    launch(8'h60, 8'h61, 1, 1, 1'b1);
    begin
      exp_t e;
      e = '0; e.cks = model_cks; q.push_back(e);
    end
    model_copy(8'h60, 8'h61, 1, 1);
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    drain();
    check("held_done_cnt", 32'(done_cnt - d0), 32'(2));
    check("held_cks", 32'(checksum), 32'h1234);

    // Full-memory copy with wrapping pointers.
    launch(8'h00, 8'h80, 256, 256, 1'b0);
    drain();
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) bad++;
    check("full_mem_words_wrong", 32'(bad), 32'(0));

    // Reset in the middle of the second WRITE.
    poke(8'h70, 16'hAAAA); poke(8'h71, 16'hBBBB);
    pre = ram[8'h91];
    launch(8'h70, 8'h90, 4, 1, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("midwrite_wr", 32'(memoryWrite), 32'(1));
    check("midwrite_addr", 32'(memoryAddress), 32'h91);
    #1 rst = 1'b0; q.delete(); model_cks = '0;
    #1 check_all_zero("reset_write");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    check("abort_m90", 32'(ram[8'h90]), 32'hAAAA);
    check("abort_m91", 32'(ram[8'h91]), 32'(pre));
    repeat (3) @(posedge clk);
    #1 check("after_abort_busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
